// File: rtl/subtractor_operand_entry.sv
// Operand entry for a 4-bit subtractor: capture minuend then subtrahend on debounced button presses.
// Define SUBTRACTOR_ENTRY_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES-long button filter.
module subtractor_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] switches,
    input  logic       enter_btn_n,
    output logic [3:0] minuend,
    output logic [3:0] subtrahend,
    output logic       operands_valid,
    output logic [1:0] state_leds
);

    localparam logic [1:0] GET_A = 2'b00;
    localparam logic [1:0] GET_B = 2'b01;
    localparam logic [1:0] READY = 2'b10;

    logic [3:0] sw_s1;
    logic [3:0] sw_s2;
    logic       btn_s1;
    logic       btn_s2;
    logic [1:0] sync_valid;
    logic       pressed_raw;
    logic       level;
    logic       level_q;
    logic       armed;
    logic       press;
    logic [1:0] state;

    // Switches share the button's synchronizer depth so captured data lines up with the press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            btn_s1     <= 1'b1;
            btn_s2     <= 1'b1;
            sync_valid <= '0;
        end else begin
            sw_s1      <= switches;
            sw_s2      <= sw_s1;
            btn_s1     <= enter_btn_n;
            btn_s2     <= btn_s1;
            sync_valid <= {sync_valid[0], 1'b1};
        end
    end

    assign pressed_raw = ~btn_s2;

`ifdef SUBTRACTOR_ENTRY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;
    logic             db_level;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (pressed_raw != db_level) begin
            if (db_cnt == CNT_LAST) begin
                db_level <= pressed_raw;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign level = db_level;
`else
    // DEBOUNCE_CYCLES has no effect in this build; the term is always true.
    assign level = pressed_raw & (DEBOUNCE_CYCLES != 0);
`endif

    // armed stays low after reset until a real released level has crossed the synchronizer,
    // so a button held through reset cannot produce a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            press   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q & armed;
            armed   <= armed | (sync_valid[1] & btn_s2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= GET_A;
            minuend        <= '0;
            subtrahend     <= '0;
            operands_valid <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (press) begin
                        minuend <= sw_s2;
                        state   <= GET_B;
                    end
                end
                GET_B: begin
                    if (press) begin
                        subtrahend     <= sw_s2;
                        state          <= READY;
                        operands_valid <= 1'b1;
                    end
                end
                READY: begin
                    if (press) begin
                        state          <= GET_A;
                        operands_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= GET_A;
                    operands_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_leds = state;

endmodule

// File: tb/tb_subtractor_operand_entry.sv
// Self-checking bench for subtractor_operand_entry; works with SUBTRACTOR_ENTRY_DEBOUNCE_EN defined or not.
module tb_subtractor_operand_entry;

    localparam int unsigned N = 4;
`ifdef SUBTRACTOR_ENTRY_DEBOUNCE_EN
    localparam int NEFF = N;
    localparam int LAT  = N + 3;
`else
    localparam int NEFF = 1;
    localparam int LAT  = 3;
`endif
    localparam int HIST = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] switches;
    logic       enter_btn_n;
    logic [3:0] minuend;
    logic [3:0] subtrahend;
    logic       operands_valid;
    logic [1:0] state_leds;

    always #5 clk = ~clk;

    subtractor_operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .switches      (switches),
        .enter_btn_n   (enter_btn_n),
        .minuend       (minuend),
        .subtrahend    (subtrahend),
        .operands_valid(operands_valid),
        .state_leds    (state_leds)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: state after each edge, derived from sampled inputs.
    logic [1:0] m_state = 2'd0;
    logic [3:0] m_min = '0;
    logic [3:0] m_sub = '0;
    logic [3:0] sw_hist [HIST];
    int         cap_q[$];
    int         cyc = 0;
    bit         m_acc = 1'b0;
    int         run = 0;
    int         run_start = 0;
    bit         need_release = 1'b1;

    function automatic void model_edge(input logic r, input logic b);
        bit pressed;
        int t;
        t = cyc;
        if (r) begin
            m_state = 2'd0;
            m_min = '0;
            m_sub = '0;
            cap_q.delete();
            m_acc = 1'b0;
            run = 0;
            need_release = 1'b1;
            return;
        end
        while (cap_q.size() > 0 && cap_q[0] == t) begin
            void'(cap_q.pop_front());
            case (m_state)
                2'd0: begin m_min = sw_hist[(t - 2) % HIST]; m_state = 2'd1; end
                2'd1: begin m_sub = sw_hist[(t - 2) % HIST]; m_state = 2'd2; end
                default: m_state = 2'd0;
            endcase
        end
        pressed = !b;
        if (need_release && !pressed) need_release = 1'b0;
        if (pressed != m_acc) begin
            if (run == 0) run_start = t;
            run++;
            if (run >= NEFF) begin
                m_acc = pressed;
                run = 0;
                if (m_acc && !need_release) cap_q.push_back(run_start + LAT);
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic step(input logic r, input logic b, input logic [3:0] s);
        rst = r;
        enter_btn_n = b;
        switches = s;
        @(posedge clk);
        cyc++;
        sw_hist[cyc % HIST] = s;
        model_edge(r, b);
        #1;
    endtask

    task automatic drive(input int n, input logic r, input logic b, input logic [3:0] s);
        for (int i = 0; i < n; i++) step(r, b, s);
    endtask

    task automatic test_reset;
        drive(3, 1'b1, 1'b1, 4'hF);
        checks++; if (minuend !== 4'd0) begin failures++; $display("FAIL reset_minuend got=%0d exp=0", minuend); end
        checks++; if (subtrahend !== 4'd0) begin failures++; $display("FAIL reset_subtrahend got=%0d exp=0", subtrahend); end
        checks++; if (operands_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", operands_valid); end
        checks++; if (state_leds !== 2'b00) begin failures++; $display("FAIL reset_leds got=%0d exp=0", state_leds); end
        drive(5, 1'b0, 1'b1, 4'hF);
        checks++; if (state_leds !== 2'b00) begin failures++; $display("FAIL reset_idle_leds got=%0d exp=0", state_leds); end
    endtask

    task automatic enter_9_3;
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(5, 1'b0, 1'b1, 4'd9);
        drive(10, 1'b0, 1'b0, 4'd9);
        drive(10, 1'b0, 1'b1, 4'd3);
        drive(10, 1'b0, 1'b0, 4'd3);
        drive(10, 1'b0, 1'b1, 4'd3);
    endtask

    task automatic test_two_operands;
        enter_9_3();
        checks++; if (minuend !== 4'd9) begin failures++; $display("FAIL two_ops_minuend got=%0d exp=9", minuend); end
        checks++; if (subtrahend !== 4'd3) begin failures++; $display("FAIL two_ops_subtrahend got=%0d exp=3", subtrahend); end
        checks++; if (operands_valid !== 1'b1) begin failures++; $display("FAIL two_ops_valid got=%0d exp=1", operands_valid); end
        checks++; if (state_leds !== 2'b10) begin failures++; $display("FAIL two_ops_leds got=%0d exp=2", state_leds); end
    endtask

    task automatic test_bounce;
        logic [1:0] exp_leds;
        logic [3:0] exp_min;
`ifdef SUBTRACTOR_ENTRY_DEBOUNCE_EN
        exp_leds = 2'b00; exp_min = 4'd0;
`else
        exp_leds = 2'b01; exp_min = 4'd5;
`endif
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(5, 1'b0, 1'b1, 4'd5);
        drive(3, 1'b0, 1'b0, 4'd5);
        drive(12, 1'b0, 1'b1, 4'd5);
        checks++; if (state_leds !== exp_leds) begin failures++; $display("FAIL bounce_leds got=%0d exp=%0d", state_leds, exp_leds); end
        checks++; if (minuend !== exp_min) begin failures++; $display("FAIL bounce_minuend got=%0d exp=%0d", minuend, exp_min); end
    endtask

    task automatic test_held;
        logic [3:0] s;
        logic [1:0] prev;
        int changes;
        s = 4'($urandom);
        changes = 0;
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(5, 1'b0, 1'b1, s);
        prev = state_leds;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, s);
            if (state_leds !== prev) changes++;
            prev = state_leds;
        end
        drive(10, 1'b0, 1'b1, s);
        if (state_leds !== prev) changes++;
        checks++; if (changes !== 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", changes); end
        checks++; if (state_leds !== 2'b01) begin failures++; $display("FAIL held_leds got=%0d exp=1", state_leds); end
        checks++; if (minuend !== s) begin failures++; $display("FAIL held_minuend got=%0d exp=%0d", minuend, s); end
    endtask

    task automatic test_ready_press;
        enter_9_3();
        drive(10, 1'b0, 1'b0, 4'hF);
        drive(10, 1'b0, 1'b1, 4'hF);
        checks++; if (state_leds !== 2'b00) begin failures++; $display("FAIL ready_leds got=%0d exp=0", state_leds); end
        checks++; if (operands_valid !== 1'b0) begin failures++; $display("FAIL ready_valid got=%0d exp=0", operands_valid); end
        checks++; if (minuend !== 4'd9) begin failures++; $display("FAIL ready_minuend got=%0d exp=9", minuend); end
        checks++; if (subtrahend !== 4'd3) begin failures++; $display("FAIL ready_subtrahend got=%0d exp=3", subtrahend); end
    endtask

    task automatic test_reset_mid;
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(5, 1'b0, 1'b1, 4'd9);
        drive(10, 1'b0, 1'b0, 4'd9);
        drive(10, 1'b0, 1'b1, 4'd9);
        checks++; if (state_leds !== 2'b01) begin failures++; $display("FAIL mid_pre_leds got=%0d exp=1", state_leds); end
        step(1'b0, 1'b0, 4'd4);
        step(1'b1, 1'b0, 4'd4);
        drive(20, 1'b0, 1'b0, 4'd4);
        checks++; if (state_leds !== 2'b00) begin failures++; $display("FAIL mid_held_leds got=%0d exp=0", state_leds); end
        checks++; if ({minuend, subtrahend, operands_valid} !== 9'd0) begin failures++; $display("FAIL mid_held_outputs got=%0h exp=0", {minuend, subtrahend, operands_valid}); end
        drive(10, 1'b0, 1'b1, 4'd4);
        checks++; if (state_leds !== 2'b00) begin failures++; $display("FAIL mid_release_leds got=%0d exp=0", state_leds); end
        drive(10, 1'b0, 1'b0, 4'd4);
        drive(5, 1'b0, 1'b1, 4'd4);
        checks++; if (state_leds !== 2'b01) begin failures++; $display("FAIL mid_repress_leds got=%0d exp=1", state_leds); end
        checks++; if (minuend !== 4'd4) begin failures++; $display("FAIL mid_repress_minuend got=%0d exp=4", minuend); end
    endtask

    task automatic test_latency;
        int found;
        found = -1;
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(6, 1'b0, 1'b1, 4'hA);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, (k < NEFF) ? 1'b0 : 1'b1, 4'hA);
            if (state_leds == 2'b01) begin
                found = k;
                break;
            end
        end
        checks++; if (found !== LAT) begin failures++; $display("FAIL latency_edges got=%0d exp=%0d", found, LAT); end
        checks++; if (minuend !== 4'hA) begin failures++; $display("FAIL latency_minuend got=%0d exp=10", minuend); end
    endtask

    task automatic test_random;
        int bad;
        int lo;
        int hi;
        bad = 0;
        drive(2, 1'b1, 1'b1, 4'd0);
        drive(5, 1'b0, 1'b1, 4'd0);
        for (int op = 0; op < 60; op++) begin
            if ($urandom_range(0, 14) == 0) begin
                lo = 0;
                step(1'b1, 1'b1, 4'($urandom));
                hi = 5;
            end else begin
                lo = $urandom_range(1, 12);
                hi = $urandom_range(1, 10);
            end
            for (int i = 0; i < lo + hi; i++) begin
                step(1'b0, (i < lo) ? 1'b0 : 1'b1, 4'($urandom));
                checks++;
                if (state_leds !== m_state) begin failures++; bad++; $display("FAIL rand_leds cyc=%0d got=%0d exp=%0d", cyc, state_leds, m_state); end
                checks++;
                if (minuend !== m_min) begin failures++; bad++; $display("FAIL rand_minuend cyc=%0d got=%0d exp=%0d", cyc, minuend, m_min); end
                checks++;
                if (subtrahend !== m_sub) begin failures++; bad++; $display("FAIL rand_subtrahend cyc=%0d got=%0d exp=%0d", cyc, subtrahend, m_sub); end
                checks++;
                if (operands_valid !== (m_state == 2'd2)) begin failures++; bad++; $display("FAIL rand_valid cyc=%0d got=%0d exp=%0d", cyc, operands_valid, m_state == 2'd2); end
                if (bad > 20) break;
            end
            if (bad > 20) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        enter_btn_n = 1'b1;
        switches = '0;
        test_reset();
        test_two_operands();
        test_bounce();
        test_held();
        test_ready_press();
        test_reset_mid();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/subtractor_operand_entry.md
SUBTRACTOR_OPERAND_ENTRY -- requirements
Module: subtractor_operand_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive clk cycles a synchronized button level must hold before it is accepted (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port switches, input, 4, the raw operand value from the board switches.
REQ-005 The block SHALL have port enter_btn_n, input, 1, the raw active-low enter push button (0 = pressed).
REQ-006 The block SHALL have port minuend, output, 4, the registered captured minuend.
REQ-007 The block SHALL have port subtrahend, output, 4, the registered captured subtrahend.
REQ-008 The block SHALL have port operands_valid, output, 1, high while both operands are captured and stable.
REQ-009 The block SHALL have port state_leds, output, 2, the FSM state: 00 = GET_A, 01 = GET_B, 10 = READY.

Function
REQ-010 Both switches and enter_btn_n SHALL pass through an identical two-flop synchronizer, so captured switch data stays cycle-aligned with the button.
REQ-011 The synchronized button SHALL be inverted to an active-high pressed level, and a one-cycle press pulse SHALL be produced only on an accepted 0->1 transition of that level.
REQ-012 A button held pressed for any duration SHALL produce exactly one press pulse, and a release SHALL produce none.
REQ-013 The FSM SHALL have exactly three states: GET_A, GET_B and READY; encoding 11 is unreachable and SHALL recover to GET_A on the next edge.
REQ-014 A press pulse in GET_A SHALL load the synchronized switches into minuend and move the FSM to GET_B.
REQ-015 A press pulse in GET_B SHALL load the synchronized switches into subtrahend, move the FSM to READY, and set operands_valid on that same edge.
REQ-016 A press pulse in READY SHALL move the FSM to GET_A and clear operands_valid on that same edge; minuend and subtrahend SHALL retain their values until overwritten.
REQ-017 In any state without a press pulse, the state and all outputs SHALL hold.
REQ-018 operands_valid SHALL be 1 exactly when the state is READY.
REQ-019 Operands SHALL be captured unsigned and unmodified; the block performs no arithmetic.

Reset
REQ-020 While rst is high, the FSM SHALL enter GET_A.
REQ-021 While rst is high, minuend, subtrahend and operands_valid SHALL be 0, state_leds SHALL be 00, and the synchronizer, debounce counter and edge registers SHALL be cleared to the "released" state.
REQ-022 rst asserted mid-entry (GET_B or READY) SHALL discard partial operands, and no press pulse SHALL be generated on the first cycle after reset releases, even if the button is held.

Configuration
REQ-023 The macro SUBTRACTOR_ENTRY_DEBOUNCE_EN SHALL select the debounce behaviour.
REQ-024 With SUBTRACTOR_ENTRY_DEBOUNCE_EN defined, the pressed level SHALL be accepted only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any change SHALL restart the counter, and the capture edge SHALL occur DEBOUNCE_CYCLES+3 clk edges after the first edge that samples enter_btn_n = 0.
REQ-025 With SUBTRACTOR_ENTRY_DEBOUNCE_EN undefined, no counter SHALL exist, the synchronized level SHALL be used directly, the capture edge SHALL occur 3 clk edges after the first edge that samples enter_btn_n = 0, and DEBOUNCE_CYCLES SHALL be ignored.

Verification (macro defined, DEBOUNCE_CYCLES=4 unless stated)
REQ-026 Scenario: switches=9, press for 10 cycles, release; switches=3, press, release -> minuend=9, subtrahend=3, operands_valid=1, state_leds=10.
REQ-027 Scenario: switches=5, enter_btn_n low for 3 cycles then high (bounce) -> no capture; state_leds stays 00 and minuend stays 0.
REQ-028 Scenario: button held low for 50 cycles in GET_A -> exactly one press pulse; state_leds=01 and minuend equals the value of switches at the capture edge.
REQ-029 Scenario: from READY with minuend=9, subtrahend=3, press -> state_leds=00 and operands_valid=0, with minuend=9 and subtrahend=3 retained.
REQ-030 Scenario: in GET_B, assert rst for 1 cycle with the button held -> all outputs 0, state_leds=00, and no capture until the button is released and pressed again.
REQ-031 Scenario: macro undefined -> a single-cycle low on enter_btn_n captures switches on the 3rd edge after it is sampled.
